qspi_target_axi_m: RTL and testbench
====================================

Name: qspi_target_axi_m

Overview:
- Quad-SPI responder (flash-style target) for the other end of the team's hs_spi QSPI master link.
- Decodes framed QSPI transactions arriving on SCK/CSn/MOSI and turns each into a single AXI4-lite master access on a local register bus.
- Returns read data on MISO after the dummy cycles.
- Single clock domain: SCK is oversampled by aclk, never used as a clock.

Parameters:
- AW, 32, address width in bits; multiple of 4; address phase lasts AW/4 SCK cycles.
- DW, 32, data width in bits; multiple of 4; data phase lasts DW/4 SCK cycles.
- DUMMY_CYCLES, 4, SCK cycles between the last address nibble and the first read-data nibble.
- CMD_WRITE, 8'h02, write opcode.
- CMD_READ, 8'h0B, read opcode.

Ports:
- aclk  in  1  system clock; must be at least 8x the SCK frequency.
- aresetn  in  1  asynchronous active-low reset.
- bus  axi4_lite_if.m  AW/DW  AXI4-lite master port; awprot/arprot tied 3'b000; wstrb all ones.
- SCK  in  1  QSPI serial clock; mode 0, idles low.
- CSn  in  1  chip select, active low; frames a transaction.
- MOSI  in  4  nibble data from the master.
- MISO  out  4  nibble data to the master.
- miso_oe  out  1  MISO output enable; high only in the read-data phase.
- busy  out  1  high from the CSn falling edge until the AXI access has completed.
- err  out  1  sticky; set on a non-OKAY response, a read not ready by end of dummy, or an unknown opcode; cleared only by reset.

Behaviour:
- Reset values: MISO=0, miso_oe=0, busy=0, err=0, all AXI valid/ready outputs 0, FSM=IDLE.
- Input sync: SCK, CSn and MOSI pass through 2-flop synchronizers. Edges are detected on the synchronized SCK; events are seen 2-3 aclk after the pin transition.
- Nibble order: MSB nibble first in every field.
- Sampling: MOSI is sampled on the detected SCK rise. MISO is updated 1 aclk after the detected SCK fall.
- FSM states: IDLE, CMD, ADDR, WDATA, WR_AXI, DUMMY, RDATA, DRAIN.
  - IDLE -> CMD on the synchronized CSn fall.
  - CMD: 2 nibbles. Opcode CMD_WRITE or CMD_READ -> ADDR. Any other opcode -> DRAIN with err set.
  - ADDR: AW/4 nibbles.
    - Write -> WDATA.
    - Read -> DUMMY; ARVALID rises 1 aclk after the last address nibble is sampled.
  - WDATA: DW/4 nibbles, then WR_AXI.
  - WR_AXI: AWVALID and WVALID rise together and each drops independently on its own handshake. BREADY=1; the access ends on the BVALID handshake. Then -> DRAIN.
  - DUMMY: count DUMMY_CYCLES SCK rises. RREADY=1 while the read is outstanding; rdata is latched into the shift register on the R handshake.
    - At the last dummy rise, if no R handshake has occurred: load DW'hFFFF_FFFF and set err.
    - -> RDATA.
  - RDATA: miso_oe=1. The first nibble is driven on the SCK fall following the last dummy rise. Each later fall shifts out the next nibble. After DW/4 nibbles -> DRAIN with miso_oe=0.
  - DRAIN: wait for CSn high and no AXI access outstanding, then -> IDLE.
- CSn rise in any state other than IDLE/DRAIN aborts the frame:
  - CMD, ADDR, or partial WDATA: no AXI write is issued; data is discarded.
  - AXI access already issued: it runs to completion, with BREADY/RREADY held at 1. A late rdata is dropped.
  - miso_oe drops 1 aclk after the synchronized CSn rise.
- CSn re-falling while in DRAIN with an AXI access outstanding: the new frame starts only after the access completes, so its first nibbles may be lost. The master must keep CSn high for at least 4 SCK periods between frames.
- A non-OKAY bresp or rresp sets err. On a read, the returned rdata is still shifted out.
- Any SCK edges seen in IDLE are ignored.

Decomposition:
- Package qspi_target_pkg holds:
  - state_t enum.
  - CMD_WRITE/CMD_READ default constants.
  - Nibble-count helper functions (AW/4, DW/4).
- Sub-module qspi_pin_sync:
  - 2-flop synchronizers for SCK, CSn and MOSI[3:0].
  - Outputs: sck_rise, sck_fall, cs_active, cs_fall, cs_rise, mosi_s.

Test Plan:
- Write: CSn low, opcode 02, address 0x0000_0010, data 0xCAFE_F00D (8 nibbles), CSn high. Expect exactly one AXI write with awaddr=0x10 and wdata=0xCAFEF00D, err=0, busy low after the B handshake.
- Read: opcode 0B, address 0x10, slave returns 0x1234_5678 with 3 aclk latency, aclk=8xSCK. After 4 dummy cycles, MISO nibbles are 1,2,...,8 and miso_oe is high for exactly 8 SCK cycles.
- Slow read: slave delays rdata beyond the dummy phase. MISO shifts out 0xFFFF_FFFF, err=1, and the late R handshake completes without hanging the FSM.
- Abort: CSn rises after 4 of the 8 write-data nibbles. No AWVALID/WVALID is ever asserted, and the next full write frame succeeds normally.
- Bad opcode 0x9F followed by 40 SCK cycles: no AXI activity, miso_oe stays 0, err=1. Reset then clears err.
- Reset mid-read: aresetn asserted during RDATA. All outputs return to reset values immediately, and a subsequent read works.

Source files
------------

// File: rtl/qspi_target_pkg.sv
// Shared types and helpers for the QSPI target that bridges frames onto AXI4-lite.
package qspi_target_pkg;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, WR_AXI, DUMMY, RDATA, DRAIN
    } state_t;

    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;
    localparam logic [7:0] CMD_READ_DEF  = 8'h0B;
    localparam logic [1:0] RESP_OKAY     = 2'b00;

    function automatic int addr_nibbles(input int aw);
        return aw / 4;
    endfunction

    function automatic int data_nibbles(input int dw);
        return dw / 4;
    endfunction

endpackage

// File: rtl/qspi_target_axi_m_if.sv
// AXI4-lite bus bundle; the QSPI target drives it through the m modport.
interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]       awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DW-1:0]       wdata;
    logic [(DW+7)/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [AW-1:0]       araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DW-1:0]       rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport m (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport s (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/qspi_pin_sync.sv
// Two-flop synchronizers for the QSPI pins plus edge detection on the synced SCK/CSn.
module qspi_pin_sync (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       sck,
    input  logic       csn,
    input  logic [3:0] mosi,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       cs_active,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic [3:0] mosi_s
);
    logic [1:0] sck_ff, csn_ff;
    logic [3:0] mosi_ff0, mosi_ff1;
    logic       sck_d, csn_d;

    // CSn resets to its idle-high level so reset release never looks like a frame start
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sck_ff   <= 2'b00;
            csn_ff   <= 2'b11;
            mosi_ff0 <= '0;
            mosi_ff1 <= '0;
            sck_d    <= 1'b0;
            csn_d    <= 1'b1;
        end else begin
            sck_ff   <= {sck_ff[0], sck};
            csn_ff   <= {csn_ff[0], csn};
            mosi_ff0 <= mosi;
            mosi_ff1 <= mosi_ff0;
            sck_d    <= sck_ff[1];
            csn_d    <= csn_ff[1];
        end
    end

    assign sck_rise  =  sck_ff[1] & ~sck_d;
    assign sck_fall  = ~sck_ff[1] &  sck_d;
    assign cs_active = ~csn_ff[1];
    assign cs_fall   = ~csn_ff[1] &  csn_d;
    assign cs_rise   =  csn_ff[1] & ~csn_d;
    assign mosi_s    = mosi_ff1;
endmodule

// File: rtl/qspi_target_axi_m.sv
// QSPI flash-style target: each framed command becomes one AXI4-lite master access.
module qspi_target_axi_m
    import qspi_target_pkg::*;
#(
    parameter int         AW           = 32,
    parameter int         DW           = 32,
    parameter int         DUMMY_CYCLES = 4,
    parameter logic [7:0] CMD_WRITE    = CMD_WRITE_DEF,
    parameter logic [7:0] CMD_READ     = CMD_READ_DEF
) (
    input  logic       aclk,
    input  logic       aresetn,
    axi4_lite_if.m     bus,
    input  logic       SCK,
    input  logic       CSn,
    input  logic [3:0] MOSI,
    output logic [3:0] MISO,
    output logic       miso_oe,
    output logic       busy,
    output logic       err
);
    localparam int CW    = 8;
    localparam int A_NIB = addr_nibbles(AW);
    localparam int D_NIB = data_nibbles(DW);

    logic       sck_rise, sck_fall, cs_active, cs_fall, cs_rise;
    logic [3:0] mosi_s;

    qspi_pin_sync u_sync (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .sck       (SCK),
        .csn       (CSn),
        .mosi      (MOSI),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .cs_active (cs_active),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .mosi_s    (mosi_s)
    );

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    op_hi;
    logic          is_rd, rd_done, cs_hi;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          awv, wv, br, av, rr;
    logic          b_hs, r_hs;
    logic [7:0]    opcode;

    assign b_hs   = bus.bvalid & br;
    assign r_hs   = bus.rvalid & rr;
    assign opcode = {op_hi, mosi_s};

    assign bus.awaddr  = addr_q;
    assign bus.awprot  = 3'b000;
    assign bus.awvalid = awv;
    assign bus.wdata   = data_q;
    assign bus.wstrb   = '1;
    assign bus.wvalid  = wv;
    assign bus.bready  = br;
    assign bus.araddr  = addr_q;
    assign bus.arprot  = 3'b000;
    assign bus.arvalid = av;
    assign bus.rready  = rr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            cnt     <= '0;
            op_hi   <= '0;
            is_rd   <= 1'b0;
            rd_done <= 1'b0;
            cs_hi   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            awv     <= 1'b0;
            wv      <= 1'b0;
            br      <= 1'b0;
            av      <= 1'b0;
            rr      <= 1'b0;
            MISO    <= '0;
            miso_oe <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            // AXI channels complete on their own, whatever the frame does; br/rr mark outstanding
            if (awv && bus.awready) awv <= 1'b0;
            if (wv && bus.wready)   wv  <= 1'b0;
            if (av && bus.arready)  av  <= 1'b0;
            if (b_hs) begin
                br <= 1'b0;
                if (bus.bresp != RESP_OKAY) err <= 1'b1;
            end
            if (r_hs) begin
                rr <= 1'b0;
                if (bus.rresp != RESP_OKAY) err <= 1'b1;
                if (state == DUMMY) begin
                    data_q  <= bus.rdata;
                    rd_done <= 1'b1;
                end
            end

            if (cs_rise && (state inside {CMD, ADDR, WDATA, WR_AXI, DUMMY, RDATA})) begin
                state   <= DRAIN;
                cnt     <= '0;
                miso_oe <= 1'b0;
                MISO    <= '0;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state <= CMD;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                    CMD: if (sck_rise) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '0) op_hi <= mosi_s;
                        else begin
                            cnt <= '0;
                            if (opcode == CMD_WRITE) begin
                                is_rd <= 1'b0;
                                state <= ADDR;
                            end else if (opcode == CMD_READ) begin
                                is_rd <= 1'b1;
                                state <= ADDR;
                            end else begin
                                err   <= 1'b1;
                                state <= DRAIN;
                            end
                        end
                    end
                    ADDR: if (sck_rise) begin
                        addr_q <= {addr_q[AW-5:0], mosi_s};
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(A_NIB - 1)) begin
                            cnt <= '0;
                            if (is_rd) begin
                                state   <= DUMMY;
                                av      <= 1'b1;
                                rr      <= 1'b1;
                                rd_done <= 1'b0;
                            end else state <= WDATA;
                        end
                    end
                    WDATA: if (sck_rise) begin
                        data_q <= {data_q[DW-5:0], mosi_s};
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(D_NIB - 1)) begin
                            cnt   <= '0;
                            state <= WR_AXI;
                            awv   <= 1'b1;
                            wv    <= 1'b1;
                            br    <= 1'b1;
                        end
                    end
                    WR_AXI: if (b_hs) state <= DRAIN;
                    DUMMY: if (sck_rise) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(DUMMY_CYCLES - 1)) begin
                            cnt     <= '0;
                            state   <= RDATA;
                            miso_oe <= 1'b1;
                            // A same-cycle R handshake still counts as in time
                            if (!rd_done && !r_hs) begin
                                data_q <= '1;
                                err    <= 1'b1;
                            end
                        end
                    end
                    RDATA: begin
                        if (sck_fall && cnt != CW'(D_NIB)) begin
                            MISO   <= data_q[DW-1 -: 4];
                            data_q <= {data_q[DW-5:0], 4'h0};
                            cnt    <= cnt + 1'b1;
                        end else if (sck_rise && cnt == CW'(D_NIB)) begin
                            state   <= DRAIN;
                            cnt     <= '0;
                            miso_oe <= 1'b0;
                            MISO    <= '0;
                        end
                    end
                    DRAIN: begin
                        if (!cs_active) cs_hi <= 1'b1;
                        // cs_hi with CSn low again means a new frame began while we waited
                        if (!br && !rr && (cs_hi || !cs_active)) begin
                            cs_hi <= 1'b0;
                            cnt   <= '0;
                            if (cs_active) state <= CMD;
                            else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qspi_target_axi_m.sv
// Directed bench: drives QSPI frames at aclk = 8x SCK against a small AXI4-lite responder.
module tb_qspi_target_axi_m;
    logic       aclk = 1'b0;
    logic       aresetn;
    logic       SCK, CSn;
    logic [3:0] MOSI, MISO;
    logic       miso_oe, busy, err;

    int errors = 0;
    int checks = 0;

    axi4_lite_if #(.AW(32), .DW(32)) bus ();

    qspi_target_axi_m dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus),
        .SCK     (SCK),
        .CSn     (CSn),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .miso_oe (miso_oe),
        .busy    (busy),
        .err     (err)
    );

    always #5 aclk = ~aclk;

    // AXI4-lite responder with programmable read latency
    int          rd_lat = 3;
    logic [31:0] rd_word = '0;
    int          rcnt = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int          awv_cyc = 0, arv_cyc = 0, oe_cyc = 0;
    logic [31:0] got_awaddr = '0, got_wdata = '0, got_araddr = '0;
    logic [3:0]  got_wstrb = '0;
    logic        aw_seen = 1'b0, w_seen = 1'b0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.arready <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
            bus.rvalid  <= 1'b0;
            bus.rresp   <= 2'b00;
            bus.rdata   <= '0;
            aw_seen     <= 1'b0;
            w_seen      <= 1'b0;
            rcnt        <= 0;
        end else begin
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
            bus.arready <= 1'b1;
            if (bus.awvalid || bus.wvalid) awv_cyc <= awv_cyc + 1;
            if (bus.arvalid) arv_cyc <= arv_cyc + 1;
            if (miso_oe) oe_cyc <= oe_cyc + 1;
            if (bus.awvalid && bus.awready) begin
                aw_cnt <= aw_cnt + 1; got_awaddr <= bus.awaddr; aw_seen <= 1'b1;
            end
            if (bus.wvalid && bus.wready) begin
                w_cnt <= w_cnt + 1; got_wdata <= bus.wdata; got_wstrb <= bus.wstrb; w_seen <= 1'b1;
            end
            if (aw_seen && w_seen && !bus.bvalid) begin
                bus.bvalid <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                ar_cnt <= ar_cnt + 1; got_araddr <= bus.araddr; rcnt <= rd_lat;
            end
            if (rcnt > 0) begin
                rcnt <= rcnt - 1;
                if (rcnt == 1) begin
                    bus.rvalid <= 1'b1; bus.rdata <= rd_word;
                end
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [3:0] smp_miso;
    logic       smp_oe;

    // One SCK period; MISO/oe are sampled just before the rise, as the master does
    task automatic nib(input logic [3:0] o);
        MOSI = o;
        #39;
        smp_miso = MISO;
        smp_oe   = miso_oe;
        #1 SCK = 1'b1;
        #40 SCK = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge aclk);
        CSn = 1'b0;
        #40;
    endtask

    task automatic end_frame();
        #40 CSn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        nib(b[7:4]);
        nib(b[3:0]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 7; i >= 0; i--) nib(w[i*4 +: 4]);
    endtask

    task automatic write_frame(input logic [31:0] a, input logic [31:0] d);
        start_frame();
        send_byte(8'h02);
        send_word(a);
        send_word(d);
        end_frame();
    endtask

    task automatic read_frame(input logic [31:0] a, output logic [31:0] word, output int oe_n);
        start_frame();
        send_byte(8'h0B);
        send_word(a);
        oe_n = 0;
        word = '0;
        for (int i = 0; i < 4; i++) begin
            nib(4'h0);
            oe_n += int'(smp_oe);
        end
        for (int i = 0; i < 8; i++) begin
            nib(4'h0);
            word = {word[27:0], smp_miso};
            oe_n += int'(smp_oe);
        end
        end_frame();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000 && busy; i++) @(negedge aclk);
        chk(tag, busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        #20 aresetn = 1'b1;
        #20;
    endtask

    logic [31:0] word;
    int          oe_n, aw0, w0, ar0, awc0, arc0, oec0;

    initial begin
        aresetn = 1'b0;
        SCK = 1'b0; CSn = 1'b1; MOSI = 4'h0;
        #12;
        chk("rst_miso", MISO, 4'h0);
        chk("rst_oe", miso_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_awv", bus.awvalid, 1'b0);
        chk("rst_wv", bus.wvalid, 1'b0);
        chk("rst_bready", bus.bready, 1'b0);
        chk("rst_arv", bus.arvalid, 1'b0);
        chk("rst_rready", bus.rready, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        #40;

        // Plain write
        aw0 = aw_cnt; w0 = w_cnt;
        write_frame(32'h0000_0010, 32'hCAFE_F00D);
        wait_idle("wr_idle");
        chk("wr_aw_cnt", 32'(aw_cnt - aw0), 32'd1);
        chk("wr_w_cnt", 32'(w_cnt - w0), 32'd1);
        chk("wr_awaddr", got_awaddr, 32'h0000_0010);
        chk("wr_wdata", got_wdata, 32'hCAFE_F00D);
        chk("wr_wstrb", got_wstrb, 4'hF);
        chk("wr_err", err, 1'b0);
        chk("wr_bready", bus.bready, 1'b0);
        #320;

        // Read with 3-cycle slave latency
        rd_lat = 3; rd_word = 32'h1234_5678; ar0 = ar_cnt;
        read_frame(32'h0000_0010, word, oe_n);
        chk("rd_data", word, 32'h1234_5678);
        chk("rd_oe_cycles", 32'(oe_n), 32'd8);
        chk("rd_oe_after", miso_oe, 1'b0);
        wait_idle("rd_idle");
        chk("rd_ar_cnt", 32'(ar_cnt - ar0), 32'd1);
        chk("rd_araddr", got_araddr, 32'h0000_0010);
        chk("rd_err", err, 1'b0);
        #320;

        // Read data arrives after the dummy phase
        rd_lat = 60; rd_word = 32'h55AA_55AA; ar0 = ar_cnt;
        read_frame(32'h0000_0010, word, oe_n);
        chk("slow_data", word, 32'hFFFF_FFFF);
        chk("slow_err", err, 1'b1);
        wait_idle("slow_idle");
        chk("slow_rready", bus.rready, 1'b0);
        chk("slow_ar_cnt", 32'(ar_cnt - ar0), 32'd1);
        do_reset();
        chk("slow_err_clr", err, 1'b0);
        #320;

        // Abort after half the write data
        aw0 = aw_cnt; awc0 = awv_cyc;
        start_frame();
        send_byte(8'h02);
        send_word(32'h0000_0020);
        for (int i = 0; i < 4; i++) nib(4'hA);
        end_frame();
        wait_idle("abort_idle");
        chk("abort_no_valid", 32'(awv_cyc - awc0), 32'd0);
        chk("abort_err", err, 1'b0);
        #320;
        write_frame(32'h0000_0024, 32'h0BAD_BEEF);
        wait_idle("abort_wr_idle");
        chk("abort_wr_cnt", 32'(aw_cnt - aw0), 32'd1);
        chk("abort_wr_addr", got_awaddr, 32'h0000_0024);
        chk("abort_wr_data", got_wdata, 32'h0BAD_BEEF);
        #320;

        // Unknown opcode
        awc0 = awv_cyc; arc0 = arv_cyc; oec0 = oe_cyc;
        start_frame();
        send_byte(8'h9F);
        for (int i = 0; i < 40; i++) nib(4'hF);
        chk("bad_err", err, 1'b1);
        end_frame();
        wait_idle("bad_idle");
        chk("bad_no_aw", 32'(awv_cyc - awc0), 32'd0);
        chk("bad_no_ar", 32'(arv_cyc - arc0), 32'd0);
        chk("bad_no_oe", 32'(oe_cyc - oec0), 32'd0);
        do_reset();
        chk("bad_err_clr", err, 1'b0);
        #320;

        // Reset in the middle of the read-data phase
        rd_lat = 3; rd_word = 32'hA5C3_0F96;
        start_frame();
        send_byte(8'h0B);
        send_word(32'h0000_0040);
        for (int i = 0; i < 7; i++) nib(4'h0);
        chk("mid_oe_on", miso_oe, 1'b1);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("mid_miso", MISO, 4'h0);
        chk("mid_oe", miso_oe, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_rready", bus.rready, 1'b0);
        chk("mid_arv", bus.arvalid, 1'b0);
        CSn = 1'b1; SCK = 1'b0;
        #19 aresetn = 1'b1;
        #320;
        rd_word = 32'h0F1E_2D3C; ar0 = ar_cnt;
        read_frame(32'h0000_0044, word, oe_n);
        chk("post_data", word, 32'h0F1E_2D3C);
        chk("post_oe_cycles", 32'(oe_n), 32'd8);
        wait_idle("post_idle");
        chk("post_araddr", got_araddr, 32'h0000_0044);
        chk("post_err", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
